mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single-ported unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage RV32 pipeline. It sequences each access through a request/acknowledge memory bus, returns read data with a one-cycle done pulse, and generates the stall signals that gate PC, IF/ID and EX/MEM advancement while an access is outstanding. Data accesses win by default; an optional fairness counter bounds fetch starvation.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits (only with ARB_FAIR_EN); must be ≥ 1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  instruction, valid with if_done
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wsel  in  2  store size (byte/half/word)
- d_rsel  in  3  load size/sign
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  load data with d_done; 0 for stores
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_wsel, mem_rsel  out  1/ADDR_W/DATA_W/2/3  registered command
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  DATA_W  valid with mem_ack
- stall_if  out  1  if_req & ~if_done
- stall_mem  out  1  d_req & ~d_done

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: if any request, pick winner, latch its command into mem_* registers and owner flag, go ISSUE. No request: stay.
- Winner: d_req has priority over if_req; with ARB_FAIR_EN, if streak == MAX_STREAK and if_req, fetch wins.
- ISSUE: mem_req = 1, command stable. On mem_ack capture mem_rdata (zero for store), go DONE. No timeout; waits indefinitely.
- DONE: pulse owner's done with captured data; go IDLE.
- Streak counter (ARB_FAIR_EN): on data grant with if_req high, increment (saturate at MAX_STREAK); on data grant with if_req low, or any fetch grant, clear.
- Requester dropping req mid-transaction: transaction still completes on the memory bus; done still pulses.
- Exactly one of if_done/d_done may be high in any cycle; never both.
- Reset: state IDLE, mem_req 0, all mem_* 0, if_done/d_done 0, if_rdata/d_rdata 0, streak 0. Reset mid-ISSUE drops mem_req immediately; no done pulse is issued for the aborted access.

## Timing
- Request seen in IDLE at cycle 0 → mem_req high cycle 1 → mem_ack earliest cycle 1 → done cycle 2. Latency = 2 + (ack wait cycles).
- Minimum 3 cycles per access (IDLE, ISSUE, DONE); back-to-back requests regranted in IDLE after DONE.
- mem_* registered outputs; stall_if/stall_mem combinational from req and done.
- Requests arriving during ISSUE/DONE are not sampled until IDLE.

## Configuration
- ARB_FAIR_EN defined: streak counter compiled in; after MAX_STREAK consecutive data grants with fetch pending, fetch is granted next.
- Undefined: strict data priority, no counter logic; fetch may starve while d_req continuously asserted.

## Test plan
- Lone fetch, if_addr=0x100, memory acks cycle 1 with 0x00500093 → if_done at cycle 2, if_rdata=0x00500093, stall_if high cycles 0–1.
- Simultaneous if_req and d_req (load 0x2000, data 0xDEADBEEF) → data granted first, d_done with 0xDEADBEEF; fetch granted at next IDLE; dones never overlap.
- Store d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_wsel=2 → mem_we=1 with same address/data/size; d_done pulses with d_rdata=0.
- ARB_FAIR_EN, MAX_STREAK=4, d_req and if_req held high → grant order D,D,D,D,I,D…; without macro, all D.
- Memory delays ack 5 cycles → mem_req and command stable for 5 cycles, done 1 cycle after ack, stalls held throughout.
- rst asserted during ISSUE → mem_req drops asynchronously, no done pulse, FSM in IDLE and streak 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetch and MEM data.
// Data wins by default. Define ARB_FAIR_EN to cap fetch starvation.
// Ports: clk, rst (async, active-low).
// Fetch side: if_req/if_addr in, if_done/if_rdata out.
// Data side: d_req/d_we/d_addr/d_wdata/d_wsel/d_rsel in, d_done/d_rdata out.
// Memory bus: registered mem_req and mem_* command out; mem_ack/mem_rdata in.
// Stalls: stall_if and stall_mem, combinational from req and done.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_wsel,
    input  logic [2:0]        d_rsel,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_wsel,
    output logic [2:0]        mem_rsel,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t state;
    logic   owner_d;
    logic   fair_hit;
    logic   grant_if;
    logic   any_req;

    if (MAX_STREAK < 1) begin : g_bad_streak
        $error("MAX_STREAK must be at least 1");
    end

`ifdef ARB_FAIR_EN
    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak;

    assign fair_hit = (streak == SW'(MAX_STREAK));

    // Counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (state == IDLE && any_req) begin
            if (grant_if || !if_req) begin
                streak <= '0;
            end else if (!fair_hit) begin
                streak <= streak + SW'(1);
            end
        end
    end
`else
    assign fair_hit = 1'b0;
`endif

    assign any_req   = if_req | d_req;
    assign grant_if  = if_req & (~d_req | fair_hit);
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wsel  <= '0;
            mem_rsel  <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d <= ~grant_if;
                        mem_req <= 1'b1;
                        state   <= ISSUE;
                        if (grant_if) begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wsel  <= 2'b00;
                            mem_rsel  <= 3'b010;
                        end else begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wsel  <= d_wsel;
                            mem_rsel  <= d_rsel;
                        end
                    end
                end
                ISSUE: begin
                    // Done is raised on entry to DONE so it lasts one cycle.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (owner_d) begin
                            d_done  <= 1'b1;
                            d_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Memory responses are driven by hand, one step per clock.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_wsel;
    logic [2:0]  d_rsel;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_wsel;
    logic [2:0]  mem_rsel;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    int n_assert = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wsel    (d_wsel),
        .d_rsel    (d_rsel),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wsel  (mem_wsel),
        .mem_rsel  (mem_rsel),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("done_overlap", {31'd0, if_done & d_done}, 32'd0);
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, mem_req}, 32'd1);
    endtask

    initial begin
        logic exp_d;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wsel    = '0;
        d_rsel    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_d_done", {31'd0, d_done}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b1;

        // Lone fetch, ack in the first ISSUE cycle
        if_req  = 1'b1;
        if_addr = 32'h100;
        #1;
        chk("f_c0_stall_if", {31'd0, stall_if}, 32'd1);
        chk("f_c0_mem_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("f_c1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f_c1_addr", mem_addr, 32'h100);
        chk("f_c1_we", {31'd0, mem_we}, 32'd0);
        chk("f_c1_stall_if", {31'd0, stall_if}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h00500093;
        step();
        mem_ack = 1'b0;
        chk("f_c2_if_done", {31'd0, if_done}, 32'd1);
        chk("f_c2_if_rdata", if_rdata, 32'h00500093);
        chk("f_c2_d_done", {31'd0, d_done}, 32'd0);
        chk("f_c2_stall_if", {31'd0, stall_if}, 32'd0);
        chk("f_c2_mem_req", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
        step();
        chk("f_c3_if_done", {31'd0, if_done}, 32'd0);

        // Simultaneous fetch and load: data first
        if_req  = 1'b1;
        if_addr = 32'h104;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h2000;
        d_rsel  = 3'b010;
        step();
        chk("s_addr_d", mem_addr, 32'h2000);
        chk("s_we", {31'd0, mem_we}, 32'd0);
        chk("s_rsel", {29'd0, mem_rsel}, 32'd2);
        chk("s_stall_if", {31'd0, stall_if}, 32'd1);
        chk("s_stall_mem", {31'd0, stall_mem}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        chk("s_d_done", {31'd0, d_done}, 32'd1);
        chk("s_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("s_if_done_lo", {31'd0, if_done}, 32'd0);
        chk("s_stall_mem_lo", {31'd0, stall_mem}, 32'd0);
        d_req = 1'b0;
        step();
        chk("s_idle_mem_req", {31'd0, mem_req}, 32'd0);
        chk("s_idle_d_done", {31'd0, d_done}, 32'd0);
        step();
        chk("s_addr_f", mem_addr, 32'h104);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        step();
        mem_ack = 1'b0;
        chk("s_if_done", {31'd0, if_done}, 32'd1);
        chk("s_if_rdata", if_rdata, 32'h11111111);
        chk("s_d_done_lo", {31'd0, d_done}, 32'd0);
        if_req = 1'b0;
        step();

        // Store with a five-cycle ack delay
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2004;
        d_wdata = 32'h12345678;
        d_wsel  = 2'd2;
        step();
        chk("st_we", {31'd0, mem_we}, 32'd1);
        chk("st_wdata", mem_wdata, 32'h12345678);
        chk("st_wsel", {30'd0, mem_wsel}, 32'd2);
        for (int k = 0; k < 5; k++) begin
            chk("st_wait_req", {31'd0, mem_req}, 32'd1);
            chk("st_wait_addr", mem_addr, 32'h2004);
            chk("st_wait_stall", {31'd0, stall_mem}, 32'd1);
            chk("st_wait_done", {31'd0, d_done}, 32'd0);
            step();
        end
        chk("st_ack_req", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        chk("st_d_done", {31'd0, d_done}, 32'd1);
        chk("st_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        step();

        // Both held: grant order
        if_req  = 1'b1;
        if_addr = 32'h108;
        d_req   = 1'b1;
        d_addr  = 32'h2008;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_FAIR_EN
            exp_d = (i != 4);
`else
            exp_d = 1'b1;
`endif
            wait_mem_req("g_mem_req");
            chk("g_addr", mem_addr, exp_d ? 32'h2008 : 32'h108);
            mem_ack   = 1'b1;
            mem_rdata = 32'(i);
            step();
            mem_ack = 1'b0;
            chk("g_d_done", {31'd0, d_done}, {31'd0, exp_d});
            chk("g_if_done", {31'd0, if_done}, {31'd0, ~exp_d});
            if (i == 5) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            step();
        end
        step();

        // Reset during ISSUE
        d_req  = 1'b1;
        d_addr = 32'h3000;
        step();
        chk("r_mem_req_pre", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("r_mem_req_async", {31'd0, mem_req}, 32'd0);
        chk("r_mem_addr", mem_addr, 32'd0);
        d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("r_d_done", {31'd0, d_done}, 32'd0);
        chk("r_if_done", {31'd0, if_done}, 32'd0);
        rst = 1'b1;
        step();
        chk("r_idle_req", {31'd0, mem_req}, 32'd0);
        chk("r_idle_d_done", {31'd0, d_done}, 32'd0);
        if_req  = 1'b1;
        if_addr = 32'h10C;
        step();
        chk("r_f_req", {31'd0, mem_req}, 32'd1);
        chk("r_f_addr", mem_addr, 32'h10C);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        chk("r_f_done", {31'd0, if_done}, 32'd1);
        chk("r_f_rdata", if_rdata, 32'hCAFEF00D);
        if_req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
